// File: rtl/zap_mac_sequencer.sv
// ---------------------------------------------------------------------------
// zap_mac_sequencer
//
// Multi-cycle multiply-accumulate controller for the shift stage. One shared
// 17x17 signed multiplier is used over four cycles to build a 64-bit signed
// or unsigned product. An optional 64-bit accumulate value is added to it,
// and the low or high 32-bit half is returned.
//
// Optional feature: define ZAP_MAC_RESULT_CACHE_EN to keep the last 64-bit
// result with its operand tag. An identical follow-up request (e.g. the
// second half of a UMLAL/SMLAL pair) is then answered the same cycle with
// no stall. Without the macro every request runs the full sequence.
//
// Ports:
//   i_clk                  clock
//   i_reset                synchronous, active-high reset
//   i_clear_from_writeback flush (highest priority, invalidates cache)
//   i_data_stall           freeze all state (middle priority)
//   i_clear_from_alu       flush (lowest priority, invalidates cache)
//   i_start                valid multiply in issue, condition passed
//   i_signed               operands are signed
//   i_high                 return result[63:32], else result[31:0]
//   i_acc                  add {i_rh, i_rn} to the product
//   i_rm, i_rs             multiplicand / multiplier
//   i_rh, i_rn             accumulate high / low word
//   o_busy                 combinational stall to issue/shift stage
//   o_done                 result valid this cycle
//   o_rd                   selected 32-bit result half
//   o_nozero               full 64-bit result is non-zero
// ---------------------------------------------------------------------------
module zap_mac_sequencer #(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic        i_high,
    input  logic        i_acc,
    input  logic [31:0] i_rm,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rh,
    input  logic [31:0] i_rn,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rd,
    output logic        o_nozero
);

    // PHY_REGS/ALU_OPS only keep this block's parameter list aligned with
    // its pipeline neighbours; this empty check is their sole reference.
    if (PHY_REGS < 1 || ALU_OPS < 1) begin : g_bad_params
    end

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_e;

    state_e      state_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] rm_q;
    logic [31:0] rs_q;
    logic        signed_q;
    logic        high_q;

    logic        hit;
    logic [63:0] hit_acc;

`ifdef ZAP_MAC_RESULT_CACHE_EN
    logic [31:0]  rh_q;
    logic [31:0]  rn_q;
    logic         acc_en_q;
    logic         cache_vld_q;
    logic [63:0]  cache_acc_q;
    logic [129:0] cache_tag_q;
    logic [129:0] req_tag;
    logic [129:0] cur_tag;

    assign req_tag = {i_rm, i_rs, i_rh, i_rn, i_signed, i_acc};
    assign cur_tag = {rm_q, rs_q, rh_q, rn_q, signed_q, acc_en_q};
    // The high/low selector is not part of the tag: both halves of one
    // product share a cache entry.
    assign hit     = (state_q == IDLE) && i_start && cache_vld_q &&
                     (req_tag == cache_tag_q);
    assign hit_acc = cache_acc_q;
`else
    assign hit     = 1'b0;
    assign hit_acc = '0;
`endif

    // -----------------------------------------------------------------------
    // Shared multiplier datapath. Operands are extended to 33 bits and split
    // into an unsigned 16-bit low part (as a positive 17-bit value) and a
    // signed 17-bit high part, so one signed 17x17 multiplier covers both
    // signed and unsigned requests.
    // -----------------------------------------------------------------------
    logic        [32:0] rm_x;
    logic        [32:0] rs_x;
    logic signed [16:0] mul_a;
    logic signed [16:0] mul_b;
    logic signed [33:0] mul_p;
    logic        [63:0] pp_ext;
    logic        [63:0] pp_sh;

    assign rm_x   = {signed_q & rm_q[31], rm_q};
    assign rs_x   = {signed_q & rs_q[31], rs_q};
    assign mul_p  = 34'(mul_a) * 34'(mul_b);
    assign pp_ext = {{30{mul_p[33]}}, mul_p};
    assign acc_d  = acc_q + pp_sh;

    // NOTE: every combinational output gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        pp_sh = '0;
        unique case (state_q)
            P0: begin
                mul_a = {1'b0, rm_x[15:0]};
                mul_b = {1'b0, rs_x[15:0]};
                pp_sh = pp_ext;
            end
            P1: begin
                mul_a = {1'b0, rm_x[15:0]};
                mul_b = rs_x[32:16];
                pp_sh = pp_ext << 16;
            end
            P2: begin
                mul_a = rm_x[32:16];
                mul_b = {1'b0, rs_x[15:0]};
                pp_sh = pp_ext << 16;
            end
            P3: begin
                mul_a = rm_x[32:16];
                mul_b = rs_x[32:16];
                pp_sh = pp_ext << 32;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer. Priority: writeback clear > data stall > ALU clear.
    // NOTE: operand and cache data registers carry no reset; they are only
    // ever observed when qualified by state_q or cache_vld_q, which do.
    // NOTE: sequential state uses non-blocking assignments only so every
    // register samples pre-edge values regardless of statement order.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
`ifdef ZAP_MAC_RESULT_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else if (i_clear_from_writeback) begin
            state_q <= IDLE;
`ifdef ZAP_MAC_RESULT_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else if (i_data_stall) begin
            // Freeze: everything, including DONE and its outputs, holds.
        end else if (i_clear_from_alu) begin
            state_q <= IDLE;
`ifdef ZAP_MAC_RESULT_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start && !hit) begin
                        rm_q     <= i_rm;
                        rs_q     <= i_rs;
                        signed_q <= i_signed;
                        high_q   <= i_high;
`ifdef ZAP_MAC_RESULT_CACHE_EN
                        rh_q     <= i_rh;
                        rn_q     <= i_rn;
                        acc_en_q <= i_acc;
`endif
                        acc_q    <= i_acc ? {i_rh, i_rn} : 64'd0;
                        state_q  <= P0;
                    end
                end
                P0: begin
                    acc_q   <= acc_d;
                    state_q <= P1;
                end
                P1: begin
                    acc_q   <= acc_d;
                    state_q <= P2;
                end
                P2: begin
                    acc_q   <= acc_d;
                    state_q <= P3;
                end
                P3: begin
                    acc_q   <= acc_d;
                    state_q <= DONE;
                end
                DONE: begin
`ifdef ZAP_MAC_RESULT_CACHE_EN
                    cache_vld_q <= 1'b1;
                    cache_acc_q <= acc_q;
                    cache_tag_q <= cur_tag;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Decoded from registered state; the hit path is combinational
    // so a cached result is returned with zero stall.
    // -----------------------------------------------------------------------
    always_comb begin
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_rd     = '0;
        o_nozero = 1'b0;
        if (!i_reset) begin
            o_busy = i_start && (state_q != DONE) && !hit;
            if (state_q == DONE) begin
                o_done   = 1'b1;
                o_rd     = high_q ? acc_q[63:32] : acc_q[31:0];
                o_nozero = |acc_q;
            end else if (hit) begin
                o_done   = 1'b1;
                o_rd     = i_high ? hit_acc[63:32] : hit_acc[31:0];
                o_nozero = |hit_acc;
            end
        end
    end

endmodule

// File: tb/tb_zap_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_zap_mac_sequencer
//
// Directed stimulus with hand-computed results. Each issued request pushes
// its expected {rd, nozero, completion cycle} into a scoreboard queue; an
// independent monitor pops and compares whenever o_done is seen. Cache-
// dependent expectations follow ZAP_MAC_RESULT_CACHE_EN.
// ---------------------------------------------------------------------------
module tb_zap_mac_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clear_from_writeback;
    logic        i_data_stall;
    logic        i_clear_from_alu;
    logic        i_start;
    logic        i_signed;
    logic        i_high;
    logic        i_acc;
    logic [31:0] i_rm;
    logic [31:0] i_rs;
    logic [31:0] i_rh;
    logic [31:0] i_rn;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rd;
    logic        o_nozero;

    zap_mac_sequencer #(.PHY_REGS(46), .ALU_OPS(32)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_start                (i_start),
        .i_signed               (i_signed),
        .i_high                 (i_high),
        .i_acc                  (i_acc),
        .i_rm                   (i_rm),
        .i_rs                   (i_rs),
        .i_rh                   (i_rh),
        .i_rn                   (i_rn),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_rd                   (o_rd),
        .o_nozero               (o_nozero)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        nz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every o_done must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rd"}, 64'(o_rd), 64'(mon_e.rd));
                check({mon_e.name, "_nozero"}, 64'(o_nozero), 64'(mon_e.nz));
                check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic drive(input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rh, input logic [31:0] rn,
                         input logic sgn, input logic high, input logic acc);
        i_rm = rm; i_rs = rs; i_rh = rh; i_rn = rn;
        i_signed = sgn; i_high = high; i_acc = acc;
        i_start = 1'b1;
    endtask

    task automatic expect_at(input logic [31:0] rd, input logic nz,
                             input int lat, input string name);
        sb.push_back('{rd: rd, nz: nz, cyc: cyc + lat, name: name});
    endtask

    // Issue cycle plus P0..P3: busy must be high for five cycles.
    task automatic busy5(input string name);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check({name, "_busy"}, 64'(o_busy), 64'd1);
            @(posedge i_clk); #1;
        end
    endtask

    task automatic wait_miss(input string name);
        busy5(name);
        @(negedge i_clk);
        check({name, "_done_busy"}, 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
    endtask

    task automatic miss_op(input logic [31:0] rm, input logic [31:0] rs,
                           input logic [31:0] rh, input logic [31:0] rn,
                           input logic sgn, input logic high, input logic acc,
                           input logic [31:0] rd, input logic nz, input string name);
        drive(rm, rs, rh, rn, sgn, high, acc);
        expect_at(rd, nz, 5, name);
        wait_miss(name);
    endtask

    // Second half of a pair: zero-stall hit with the cache, full miss without.
    task automatic pair_op(input logic [31:0] rm, input logic [31:0] rs,
                           input logic [31:0] rh, input logic [31:0] rn,
                           input logic sgn, input logic high, input logic acc,
                           input logic [31:0] rd, input logic nz, input string name);
`ifdef ZAP_MAC_RESULT_CACHE_EN
        drive(rm, rs, rh, rn, sgn, high, acc);
        expect_at(rd, nz, 0, name);
        @(negedge i_clk);
        check({name, "_hit_busy"}, 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
`else
        miss_op(rm, rs, rh, rn, sgn, high, acc, rd, nz, name);
`endif
    endtask

    task automatic outputs_zero(input string name);
        @(negedge i_clk);
        check({name, "_busy"}, 64'(o_busy), 64'd0);
        check({name, "_done"}, 64'(o_done), 64'd0);
        check({name, "_rd"}, 64'(o_rd), 64'd0);
        check({name, "_nozero"}, 64'(o_nozero), 64'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_clear_from_writeback = 1'b0;
        i_data_stall = 1'b0;
        i_clear_from_alu = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_start = 1'b1;            // outputs must stay 0 even with a request
        outputs_zero("reset");
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // Unsigned 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        miss_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                32'h00000001, 1'b1, "u_low");
        pair_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0,
                32'hFFFFFFFE, 1'b1, "u_high");

        // Signed -1 * 2 = 0xFFFFFFFF_FFFFFFFE
        miss_op(32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                32'hFFFFFFFE, 1'b1, "s_low");
        pair_op(32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0,
                32'hFFFFFFFF, 1'b1, "s_high");

        // 3*5 + 0x1_FFFFFFF2 = 0x2_00000001
        miss_op(32'd3, 32'd5, 32'd1, 32'hFFFFFFF2, 1'b0, 1'b0, 1'b1,
                32'h00000001, 1'b1, "acc_low");
        pair_op(32'd3, 32'd5, 32'd1, 32'hFFFFFFF2, 1'b0, 1'b1, 1'b1,
                32'h00000002, 1'b1, "acc_high");

        // Zero product
        miss_op(32'd0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                32'd0, 1'b0, "zero");

        // 6*7 = 42, cached if the cache exists
        miss_op(32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                32'd42, 1'b1, "x_low");

        // Flush a different request in P2; the ALU clear also invalidates the
        // cache, so the high half of 6*7 must miss. Issued the very next cycle.
        drive(32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("flush_y_busy", 64'(o_busy), 64'd1);
            @(posedge i_clk); #1;
        end
        i_clear_from_alu = 1'b1;   // state is P2 this cycle
        @(negedge i_clk);
        check("flush_y_p2_busy", 64'(o_busy), 64'd1);
        @(posedge i_clk); #1;
        i_clear_from_alu = 1'b0;
        miss_op(32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0,
                32'd0, 1'b1, "x_high_after_flush");

        // Writeback clear and data stall together in P1: the clear wins.
        drive(32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check("wb_z_busy", 64'(o_busy), 64'd1);
            @(posedge i_clk); #1;
        end
        i_clear_from_writeback = 1'b1;
        i_data_stall = 1'b1;
        @(posedge i_clk); #1;
        i_clear_from_writeback = 1'b0;
        i_data_stall = 1'b0;
        miss_op(32'd4, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                32'd20, 1'b1, "wb_w");

        // Stall held three cycles in DONE: 0x10000^2 = 2^32, high half = 1.
        drive(32'h00010000, 32'h00010000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 5; i < 9; i++) expect_at(32'd1, 1'b1, i, "stall_done");
        busy5("stall");
        i_data_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("stall_hold_busy", 64'(o_busy), 64'd0);
            @(posedge i_clk); #1;
        end
        i_data_stall = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        check("stall_release_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;

        // Reset asserted in P1 with the request still presented.
        drive(32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check("rst_p1_pre_busy", 64'(o_busy), 64'd1);
            @(posedge i_clk); #1;
        end
        i_reset = 1'b1;
        outputs_zero("rst_p1");
        @(posedge i_clk); #1;
        i_start = 1'b0;
        outputs_zero("rst_p1_hold");
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        // Back in IDLE with an empty cache: full 5-cycle sequence.
        miss_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                32'h00000001, 1'b1, "post_reset");

        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
